// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: stall/flush encodings, FSM states and the
// F/D pipeline register layout.
package fetch_stage_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stall_t;

  // Flush is active-low: FLUSH clears, KEEP leaves the register alone.
  typedef enum logic {
    FLUSH = 1'b0,
    KEEP  = 1'b1
  } flush_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic        PCSrc;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] WD3;
  } fetch_decode_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_decode_reg.sv
// F/D pipeline register: flush beats stall, stall beats load; with neither
// stall nor load the contents stay but the valid flag drops.
module fetch_decode_reg
  import fetch_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          load_i,
  input  fetch_decode_t load_data_i,
  output fetch_decode_t fd_o,
  output logic          fd_valid_o
);

  fetch_decode_t fd_d;
  fetch_decode_t fd_q;
  logic          valid_d;
  logic          valid_q;

  // Next-state selection by priority
  always_comb begin
    fd_d    = fd_q;
    valid_d = valid_q;
    if (flush_i == FLUSH) begin
      fd_d    = '0;
      valid_d = 1'b0;
    end else if (stall_i == STALL) begin
      fd_d    = fd_q;
      valid_d = valid_q;
    end else if (load_i) begin
      fd_d    = load_data_i;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Register update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      fd_q    <= fd_d;
      valid_q <= valid_d;
    end
  end

  assign fd_o       = fd_q;
  assign fd_valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request at a time, a
// one-entry hold buffer for words returning under decode stall, and redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          StallF,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          PCSrc,
  input  logic [31:0]   BranchTarget,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_valid,
  input  logic [31:0]   imem_rdata,
  output fetch_decode_t fd_out,
  output logic          fd_valid,
  output logic          fetch_busy
);

  fetch_state_t  state_d;
  fetch_state_t  state_q;
  logic [31:0]   pc_d;
  logic [31:0]   pc_q;
  logic          hold_valid_d;
  logic          hold_valid_q;
  logic [31:0]   hold_instr_d;
  logic [31:0]   hold_instr_q;
  logic [31:0]   hold_pc_d;
  logic [31:0]   hold_pc_q;
  logic          fd_load_s;
  logic [31:0]   load_instr_s;
  logic [31:0]   load_pc_s;
  logic [31:0]   fetch_addr_s;
  fetch_decode_t fd_load_data_s;

  assign fetch_addr_s = word_align(pc_q);

  // FSM, PC and hold-buffer next state; a redirect overrides the PC last
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    fd_load_s    = 1'b0;
    load_instr_s = hold_instr_q;
    load_pc_s    = hold_pc_q;
    case (state_q)
      IDLE: begin
        state_d = ISSUE;
      end
      ISSUE: begin
        if (!PCSrc && (StallF == RUN)) begin
          state_d = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (imem_valid) begin
          if (PCSrc) begin
            state_d = ISSUE;
          end else if (StallD == RUN) begin
            fd_load_s    = 1'b1;
            load_instr_s = imem_rdata;
            load_pc_s    = fetch_addr_s;
            pc_d         = pc_q + PC_STEP;
            state_d      = ISSUE;
          end else begin
            hold_valid_d = 1'b1;
            hold_instr_d = imem_rdata;
            hold_pc_d    = fetch_addr_s;
            pc_d         = pc_q + PC_STEP;
            state_d      = HOLD;
          end
        end else if (PCSrc) begin
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (PCSrc) begin
          hold_valid_d = 1'b0;
          state_d      = ISSUE;
        end else if (StallD == RUN) begin
          fd_load_s    = hold_valid_q;
          hold_valid_d = 1'b0;
          state_d      = ISSUE;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        // The redirected-away response still has to come back before reissuing.
        if (imem_valid) begin
          state_d = ISSUE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (PCSrc) begin
      pc_d = word_align(BranchTarget);
    end else begin
      pc_d = pc_d;
    end
  end

  // State, PC and hold buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_instr_q <= 32'h0000_0000;
      hold_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  always_comb begin
    fd_load_data_s.PCSrc       = 1'b0;
    fd_load_data_s.Instruction = load_instr_s;
    fd_load_data_s.PC          = load_pc_s;
    fd_load_data_s.WD3         = load_pc_s + 32'd8;
  end

  fetch_decode_reg u_fd_reg (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (StallD),
    .flush_i     (FlushD),
    .load_i      (fd_load_s),
    .load_data_i (fd_load_data_s),
    .fd_o        (fd_out),
    .fd_valid_o  (fd_valid)
  );

  // A redirect in the same cycle would waste the request, so it is suppressed.
  assign imem_req   = (state_q == ISSUE) && (StallF == RUN) && !PCSrc;
  assign imem_addr  = fetch_addr_s;
  assign fetch_busy = (state_q == WAIT) || (state_q == DRAIN);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory model answers requests, a
// transaction-level model predicts deliveries, a monitor scores the F/D output.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          StallF = 1'b0;
  logic          StallD = 1'b0;
  logic          FlushD = 1'b1;
  logic          PCSrc = 1'b0;
  logic [31:0]   BranchTarget = 32'h0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_valid = 1'b0;
  logic [31:0]   imem_rdata = 32'h0;
  fetch_decode_t fd_out;
  logic          fd_valid;
  logic          fetch_busy;

  fetch_stage #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .fd_out(fd_out), .fd_valid(fd_valid), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_req = 0;
  int n_deliv = 0;
  int since_rst = 0;
  fetch_decode_t exp_q[$];

  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  bit          outstanding;
  bit          resp_dead;
  bit          held;
  logic [31:0] exp_pc;
  logic [31:0] req_pc;
  logic [31:0] held_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic fetch_decode_t mk(input logic [31:0] pc);
    fetch_decode_t e;
    e.PCSrc       = 1'b0;
    e.Instruction = mem_word(pc);
    e.PC          = pc;
    e.WD3         = pc + 32'd8;
    return e;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [96:0] act, input logic [96:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    mem_busy    = 1'b0;
    mem_cnt     = 0;
    outstanding = 1'b0;
    resp_dead   = 1'b0;
    held        = 1'b0;
    exp_pc      = RESET_PC;
    imem_valid  = 1'b0;
    exp_q.delete();
  endtask

  // Called at posedge+1; drives one cycle, checks requests, applies the model at the edge.
  task automatic run_cycles(input int n, input int lat_lo, input int lat_hi, input bit rnd);
    for (int c = 0; c < n; c++) begin
      bit          acc;
      logic [31:0] pc_del;
      if (rnd) begin
        StallF       = ($urandom_range(0, 4) == 0) ? STALL : RUN;
        StallD       = ($urandom_range(0, 3) == 0) ? STALL : RUN;
        FlushD       = ($urandom_range(0, 11) == 0) ? FLUSH : KEEP;
        PCSrc        = ($urandom_range(0, 11) == 0);
        BranchTarget = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      end else begin
        StallF = RUN;
        StallD = RUN;
        FlushD = KEEP;
        PCSrc  = 1'b0;
      end
      imem_valid = 1'b0;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(mem_addr);
          mem_busy   = 1'b0;
        end
      end
      @(negedge clk);
      chk(fetch_busy == outstanding, "fetch_busy", 97'(fetch_busy), 97'(outstanding));
      if (since_rst == 0) chk(imem_req == 1'b0, "idle_no_req", 97'(imem_req), 97'(0));
      if (since_rst == 1 && StallF == RUN && !PCSrc)
        chk(imem_req == 1'b1 && imem_addr == RESET_PC, "first_req", {64'(imem_req), imem_addr}, {64'(1), RESET_PC});
      if (imem_req) begin
        n_req++;
        chk(imem_addr == exp_pc, "req_addr", 97'(imem_addr), 97'(exp_pc));
        chk(!outstanding && !held, "req_allowed", 97'({outstanding, held}), 97'(0));
        outstanding = 1'b1;
        mem_busy    = 1'b1;
        mem_addr    = imem_addr;
        req_pc      = exp_pc;
        resp_dead   = 1'b0;
        mem_cnt     = $urandom_range(lat_lo, lat_hi);
      end
      @(posedge clk);
      acc = 1'b0;
      if (imem_valid) begin
        outstanding = 1'b0;
        if (!resp_dead && !PCSrc) begin
          acc    = 1'b1;
          exp_pc = req_pc + PC_STEP;
        end
      end
      if (PCSrc) begin
        resp_dead = 1'b1;
        held      = 1'b0;
        exp_pc    = BranchTarget & 32'hFFFF_FFFC;
      end else if (acc || held) begin
        pc_del = acc ? req_pc : held_pc;
        if (StallD == STALL) begin
          held    = 1'b1;
          held_pc = pc_del;
        end else begin
          held = 1'b0;
          if (FlushD == KEEP) exp_q.push_back(mk(pc_del));
        end
      end
      since_rst++;
      #1;
    end
  endtask

  // Monitor: tracks what F/D should hold and pops the scoreboard on each new delivery
  initial begin
    fetch_decode_t mdl;
    fetch_decode_t got;
    logic sd, fl, r;
    mdl = '0;
    forever begin
      @(posedge clk);
      sd = StallD;
      fl = FlushD;
      r  = rst;
      @(negedge clk);
      if (r || rst) begin
        mdl = '0;
        chk(fd_valid == 1'b0, "rst_fd_valid", 97'(fd_valid), 97'(0));
      end else if (fl == FLUSH) begin
        mdl = '0;
        chk(fd_valid == 1'b0 && fd_out == '0, "flush", {fd_out[95:0], fd_valid}, 97'(0));
      end else if (sd == STALL) begin
        chk(fd_out == mdl, "stall_hold", fd_out, mdl);
      end else if (fd_valid) begin
        chk(exp_q.size() != 0, "unexpected_delivery", fd_out, 97'(0));
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          n_deliv++;
          chk(fd_out == got, "delivery", fd_out, got);
          mdl = got;
        end
      end else begin
        chk(exp_q.size() == 0, "missing_delivery", 97'(exp_q.size()), 97'(0));
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(imem_req == 1'b0, "rst_imem_req", 97'(imem_req), 97'(0));
    chk(imem_addr == RESET_PC, "rst_imem_addr", 97'(imem_addr), 97'(RESET_PC));
    chk(fd_out == '0, "rst_fd_out", fd_out, 97'(0));
    chk(fetch_busy == 1'b0, "rst_fetch_busy", 97'(fetch_busy), 97'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    since_rst = 0;
    run_cycles(12, 1, 1, 1'b0);
    run_cycles(16, 3, 3, 1'b0);
    run_cycles(3000, 1, 4, 1'b1);
    run_cycles(10, 1, 1, 1'b0);
    // Reset while a request is outstanding
    for (int k = 0; k < 40 && !(outstanding && mem_busy); k++) run_cycles(1, 3, 3, 1'b0);
    chk(outstanding && mem_busy, "reach_wait", 97'({outstanding, mem_busy}), 97'(3));
    rst = 1'b1;
    model_reset();
    #1;
    chk(imem_req == 1'b0, "wait_rst_req", 97'(imem_req), 97'(0));
    chk(imem_addr == RESET_PC, "wait_rst_addr", 97'(imem_addr), 97'(RESET_PC));
    chk(fd_valid == 1'b0 && fd_out == '0, "wait_rst_fd", {fd_out[95:0], fd_valid}, 97'(0));
    chk(fetch_busy == 1'b0, "wait_rst_busy", 97'(fetch_busy), 97'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    since_rst = 0;
    run_cycles(20, 1, 2, 1'b0);
    chk(n_req > 600, "request_count", 97'(n_req), 97'(600));
    chk(n_deliv > 300, "delivery_count", 97'(n_deliv), 97'(300));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
